// File: rtl/tmr_resp_tracker.sv
// Gates the voted OBI request, tracks outstanding transactions and fans the bus response out to all harts.
// Latency: request gating and response fan-out are combinational (0 cycles); counter and FSM update on clk_i.
// Backpressure: req is withheld at MAX_OUTSTANDING or outside RUN; optional drain watchdog under TMR_RESP_TIMEOUT_EN.
package tmr_resp_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module tmr_resp_tracker
    import tmr_resp_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  obi_req_t                     voted_req_i,
    output obi_req_t                     bus_req_o,
    input  obi_resp_t                    bus_resp_i,
    output obi_resp_t [NHARTS-1:0]       core_resp_o,
    input  logic                         voter_error_i,
    input  logic [NHARTS-1:0]            voter_error_id_i,
    output logic                         recover_req_o,
    input  logic                         recover_ack_i,
    output logic [NHARTS-1:0]            faulty_id_o,
    output logic [CW-1:0]                outstanding_o,
    output logic                         protocol_err_o,
    output logic                         timeout_o
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    logic [1:0] state;
    logic       err_in;
    logic       req_ok;
    logic       inc;
    logic       dec;
    logic       drain_done;
    logic       wd_hit;

    assign err_in = voter_error_i & enable_i;
    assign req_ok = voted_req_i.req & (state == RUN) & ~err_in
                  & (outstanding_o < CW'(MAX_OUTSTANDING));
    assign inc    = req_ok & bus_resp_i.gnt;
    assign dec    = bus_resp_i.rvalid;

    // Done draining once the last in-flight response has been seen (or none was pending).
    assign drain_done = (state == DRAIN)
                      & (((outstanding_o == '0) & ~dec) | ((outstanding_o == CW'(1)) & dec));

    always_comb begin
        bus_req_o     = voted_req_i;
        bus_req_o.req = req_ok;
    end

    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            core_resp_o[i]        = bus_resp_i;
            core_resp_o[i].gnt    = bus_resp_i.gnt & req_ok;
        end
    end

`ifdef TMR_RESP_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_hit = (state == DRAIN) & ~drain_done & (outstanding_o != '0)
                  & (wd_cnt >= 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if ((state == RUN) && err_in) begin
                wd_cnt <= '0;
            end else if ((state == DRAIN) && (wd_cnt != 16'hFFFF)) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_hit) begin
                timeout_o <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= RUN;
            outstanding_o  <= '0;
            faulty_id_o    <= '0;
            recover_req_o  <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            // A watchdog expiry abandons whatever is still in flight.
            if (wd_hit) begin
                outstanding_o <= '0;
            end else if (inc && !dec) begin
                outstanding_o <= outstanding_o + CW'(1);
            end else if (dec && !inc) begin
                if (outstanding_o == '0) begin
                    protocol_err_o <= 1'b1;
                end else begin
                    outstanding_o <= outstanding_o - CW'(1);
                end
            end

            case (state)
                RUN: begin
                    if (err_in) begin
                        faulty_id_o <= voter_error_id_i;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (err_in) begin
                        faulty_id_o <= faulty_id_o | voter_error_id_i;
                    end
                    if (drain_done || wd_hit) begin
                        state         <= RECOVER;
                        recover_req_o <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (recover_ack_i) begin
                        state         <= RUN;
                        recover_req_o <= 1'b0;
                        faulty_id_o   <= '0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_resp_tracker.sv
// Directed bench for tmr_resp_tracker: normal flow, outstanding limit, error episodes, protocol error, reset, watchdog.
module tb_tmr_resp_tracker;
    import tmr_resp_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             enable;
    obi_req_t         voted_req;
    obi_req_t         bus_req;
    obi_resp_t        bus_resp;
    obi_resp_t [2:0]  core_resp;
    logic             voter_error;
    logic [2:0]       voter_error_id;
    logic             recover_req;
    logic             recover_ack;
    logic [2:0]       faulty_id;
    logic [1:0]       outstanding;
    logic             protocol_err;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    tmr_resp_tracker #(
        .NHARTS          (3),
        .MAX_OUTSTANDING (2),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .voted_req_i      (voted_req),
        .bus_req_o        (bus_req),
        .bus_resp_i       (bus_resp),
        .core_resp_o      (core_resp),
        .voter_error_i    (voter_error),
        .voter_error_id_i (voter_error_id),
        .recover_req_o    (recover_req),
        .recover_ack_i    (recover_ack),
        .faulty_id_o      (faulty_id),
        .outstanding_o    (outstanding),
        .protocol_err_o   (protocol_err),
        .timeout_o        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic fan(input string tag, input logic g, input logic v, input logic [31:0] d);
        for (int i = 0; i < 3; i++) begin
            chk(tag, 64'(core_resp[i]), 64'({g, v, d}));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic g, input logic v, input logic [31:0] d,
                       input logic e, input logic [2:0] id, input logic ack);
        voted_req.req  = r;
        bus_resp.gnt   = g;
        bus_resp.rvalid = v;
        bus_resp.rdata = d;
        voter_error    = e;
        voter_error_id = id;
        recover_ack    = ack;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b1;
        voted_req      = '0;
        voted_req.addr = 32'h1000_0040;
        voted_req.we   = 1'b1;
        voted_req.be   = 4'hF;
        voted_req.wdata = 32'hCAFE_0001;
        bus_resp       = '0;
        voter_error    = 1'b0;
        voter_error_id = '0;
        recover_ack    = 1'b0;
        #12;
        chk("rst_req", 64'(bus_req.req), 64'd0);
        chk("rst_out", 64'(outstanding), 64'd0);
        chk("rst_faulty", 64'(faulty_id), 64'd0);
        chk("rst_recover", 64'(recover_req), 64'd0);
        chk("rst_proto", 64'(protocol_err), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        fan("rst_core", 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Normal flow: three back-to-back requests, response one cycle behind
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        chk("nrm_req", 64'(bus_req.req), 64'd1);
        chk("nrm_addr", 64'(bus_req.addr), 64'h1000_0040);
        chk("nrm_wdata", 64'(bus_req.wdata), 64'hCAFE_0001);
        fan("nrm_core0", 1'b1, 1'b0, 32'h0);
        cyc();
        chk("nrm_out1", 64'(outstanding), 64'd1);
        drv(1, 1, 1, 32'hA5A5_0001, 0, 3'b000, 0);
        fan("nrm_core1", 1'b1, 1'b1, 32'hA5A5_0001);
        cyc();
        chk("nrm_out2", 64'(outstanding), 64'd1);
        drv(1, 1, 1, 32'h5A5A_0002, 0, 3'b000, 0);
        fan("nrm_core2", 1'b1, 1'b1, 32'h5A5A_0002);
        cyc();
        chk("nrm_out3", 64'(outstanding), 64'd1);
        drv(0, 0, 1, 32'h1234_5678, 0, 3'b000, 0);
        fan("nrm_core3", 1'b0, 1'b1, 32'h1234_5678);
        cyc();
        chk("nrm_out0", 64'(outstanding), 64'd0);

        // Outstanding limit
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        cyc();
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        cyc();
        chk("lim_out2", 64'(outstanding), 64'd2);
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        chk("lim_req_blk", 64'(bus_req.req), 64'd0);
        fan("lim_gnt_blk", 1'b0, 1'b0, 32'h0);
        cyc();
        chk("lim_out_hold", 64'(outstanding), 64'd2);
        drv(1, 1, 1, 32'h0000_00AA, 0, 3'b000, 0);
        chk("lim_req_blk_rv", 64'(bus_req.req), 64'd0);
        fan("lim_gnt_blk_rv", 1'b0, 1'b1, 32'h0000_00AA);
        cyc();
        chk("lim_out_dec", 64'(outstanding), 64'd1);
        drv(1, 1, 1, 32'h0000_00BB, 0, 3'b000, 0);
        chk("lim_req_open", 64'(bus_req.req), 64'd1);
        cyc();
        chk("lim_out_incdec", 64'(outstanding), 64'd1);
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        cyc();
        chk("lim_out_full", 64'(outstanding), 64'd2);

        // Error episode with accumulation
        drv(1, 1, 0, 32'h0, 1, 3'b010, 0);
        chk("err_req_blk", 64'(bus_req.req), 64'd0);
        fan("err_gnt_blk", 1'b0, 1'b0, 32'h0);
        cyc();
        chk("err_faulty", 64'(faulty_id), 64'd2);
        chk("err_recover0", 64'(recover_req), 64'd0);
        drv(1, 0, 1, 32'h0000_0C01, 1, 3'b100, 0);
        fan("drn_rv_fwd", 1'b0, 1'b1, 32'h0000_0C01);
        cyc();
        chk("drn_faulty_acc", 64'(faulty_id), 64'd6);
        chk("drn_out1", 64'(outstanding), 64'd1);
        drv(1, 1, 1, 32'h0000_0C02, 0, 3'b000, 0);
        chk("drn_req_blk", 64'(bus_req.req), 64'd0);
        cyc();
        chk("drn_out0", 64'(outstanding), 64'd0);
        chk("rec_req1", 64'(recover_req), 64'd1);
        drv(1, 1, 0, 32'h0, 1, 3'b001, 0);
        chk("rec_req_blk", 64'(bus_req.req), 64'd0);
        cyc();
        chk("rec_err_ign", 64'(faulty_id), 64'd6);
        chk("rec_hold", 64'(recover_req), 64'd1);
        drv(1, 0, 0, 32'h0, 0, 3'b000, 1);
        cyc();
        chk("ack_recover0", 64'(recover_req), 64'd0);
        chk("ack_faulty0", 64'(faulty_id), 64'd0);
        drv(1, 0, 0, 32'h0, 0, 3'b000, 0);
        chk("ack_run_req", 64'(bus_req.req), 64'd1);

        // Error ignored while disabled
        enable = 1'b0;
        drv(1, 0, 0, 32'h0, 1, 3'b010, 0);
        chk("dis_req", 64'(bus_req.req), 64'd1);
        cyc();
        chk("dis_faulty", 64'(faulty_id), 64'd0);
        enable = 1'b1;
        drv(1, 0, 0, 32'h0, 0, 3'b000, 0);
        chk("dis_still_run", 64'(bus_req.req), 64'd1);

        // rvalid with nothing outstanding
        drv(0, 0, 1, 32'h0, 0, 3'b000, 0);
        cyc();
        chk("prot_err", 64'(protocol_err), 64'd1);
        chk("prot_out0", 64'(outstanding), 64'd0);

        // Reset while in RECOVER
        drv(0, 0, 0, 32'h0, 1, 3'b001, 0);
        cyc();
        drv(0, 0, 0, 32'h0, 0, 3'b000, 0);
        cyc();
        chk("rr_recover1", 64'(recover_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_recover0", 64'(recover_req), 64'd0);
        chk("rr_faulty0", 64'(faulty_id), 64'd0);
        chk("rr_proto0", 64'(protocol_err), 64'd0);
        rst_n = 1'b1;
        cyc();
        drv(1, 0, 0, 32'h0, 0, 3'b000, 0);
        chk("rr_run_req", 64'(bus_req.req), 64'd1);

`ifdef TMR_RESP_TIMEOUT_EN
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        cyc();
        drv(0, 0, 0, 32'h0, 1, 3'b001, 0);
        cyc();
        drv(0, 0, 0, 32'h0, 0, 3'b000, 0);
        repeat (7) cyc();
        chk("to_not_yet", 64'(timeout), 64'd0);
        chk("to_rec_not_yet", 64'(recover_req), 64'd0);
        chk("to_out_pend", 64'(outstanding), 64'd1);
        cyc();
        chk("to_set", 64'(timeout), 64'd1);
        chk("to_recover", 64'(recover_req), 64'd1);
        chk("to_out_forced", 64'(outstanding), 64'd0);
        drv(0, 0, 1, 32'h0, 0, 3'b000, 0);
        cyc();
        chk("to_late_rv", 64'(protocol_err), 64'd1);
        chk("to_sticky", 64'(timeout), 64'd1);
`else
        drv(1, 1, 0, 32'h0, 0, 3'b000, 0);
        cyc();
        drv(0, 0, 0, 32'h0, 1, 3'b001, 0);
        cyc();
        drv(0, 0, 0, 32'h0, 0, 3'b000, 0);
        repeat (20) cyc();
        chk("nto_tied0", 64'(timeout), 64'd0);
        chk("nto_waits", 64'(recover_req), 64'd0);
        chk("nto_out_pend", 64'(outstanding), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
